// File: rtl/program_sequencer_decoder_if.sv
// Program-memory and CU control bundle for the program sequencer/decoder.
// master: the sequencer (drives address and decode); slave: memory/CU side.
interface program_sequencer_decoder_if;
  logic [7:0] pm_addr;
  logic [7:0] pm_data;
  logic       r_eq_0;
  logic [7:0] ir;
  logic [3:0] ir_nibble;
  logic [3:0] source_sel;
  logic [8:0] reg_en;
  logic       i_sel;
  logic       x_sel;
  logic       y_sel;
  logic       NOPD8;
  logic       NOPDF;

  modport master (
    input  pm_data, r_eq_0,
    output pm_addr, ir, ir_nibble, source_sel, reg_en,
           i_sel, x_sel, y_sel, NOPD8, NOPDF
  );

  modport slave (
    output pm_data, r_eq_0,
    input  pm_addr, ir, ir_nibble, source_sel, reg_en,
           i_sel, x_sel, y_sel, NOPD8, NOPDF
  );
endinterface

// File: rtl/program_sequencer_decoder.sv
// Fetch/decode stage feeding the computational unit.
// Holds pc, ir and ir_pc; decodes ir into CU controls; executes jmp/jnz
// within the 16-word page of the jump instruction.
// Optional macro JUMP_FLUSH_EN: a taken jump replaces the fetched word with
// NOP_INSTR (no delay slot). Undefined: the word after a jump always executes.
module program_sequencer_decoder #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [7:0] NOP_INSTR    = 8'hC8
) (
  input logic                         clk,
  input logic                         sync_reset,
  program_sequencer_decoder_if.master bus
);

  logic [7:0] pc;
  logic [7:0] ir_q;
  logic [7:0] ir_pc;
  logic       taken;
  logic [7:0] target;

  logic [3:0] src_sel;
  logic [8:0] en;
  logic [3:0] nib;
  logic       isel;
  logic       xs;
  logic       ys;
  logic       nop_d8;
  logic       nop_df;
  logic [2:0] dst;
  logic       dst_valid;
  logic       src_dm;

  function automatic logic [8:0] dst_onehot(input logic [2:0] d);
    logic [8:0] oh;
    oh = '0;
    case (d)
      3'd4:    oh[8] = 1'b1;
      default: oh[d] = 1'b1;
    endcase
    return oh;
  endfunction

  assign taken  = (ir_q[7:4] == 4'hE) || ((ir_q[7:4] == 4'hF) && !bus.r_eq_0);
  assign target = {ir_pc[7:4], ir_q[3:0]};

  // Fetch pipeline: pc advances or jumps, ir captures the fetched word.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc    <= RESET_VECTOR;
      ir_q  <= NOP_INSTR;
      ir_pc <= RESET_VECTOR;
    end else begin
      pc    <= taken ? target : pc + 8'd1;
      ir_pc <= pc;
`ifdef JUMP_FLUSH_EN
      ir_q  <= taken ? NOP_INSTR : bus.pm_data;
`else
      ir_q  <= bus.pm_data;
`endif
    end
  end

  // Combinational instruction decode; reset overrides to "clear r" only.
  always_comb begin
    src_sel   = 4'd10;
    en        = '0;
    nib       = ir_q[3:0];
    isel      = 1'b0;
    xs        = 1'b0;
    ys        = 1'b0;
    nop_d8    = (ir_q == 8'hD8);
    nop_df    = (ir_q == 8'hDF);
    dst       = 3'd0;
    dst_valid = 1'b0;
    src_dm    = 1'b0;

    if (!ir_q[7]) begin
      dst       = ir_q[6:4];
      dst_valid = 1'b1;
      src_sel   = 4'd8;
    end else if (ir_q[7:6] == 2'b10) begin
      dst       = ir_q[5:3];
      dst_valid = 1'b1;
      src_sel   = (ir_q[5:3] == ir_q[2:0]) ? 4'd9 : {1'b0, ir_q[2:0]};
      src_dm    = (ir_q[2:0] == 3'd7);
    end else if (ir_q[7:5] == 3'b110) begin
      en = 9'h010;
      xs = ir_q[4];
      ys = ir_q[3];
    end

    // Any dm access post-increments i, unless i itself is being written.
    if (dst_valid) begin
      en = dst_onehot(dst);
      if ((dst == 3'd7 || src_dm) && dst != 3'd6) begin
        en[6] = 1'b1;
        isel  = 1'b1;
      end
    end

    if (sync_reset) begin
      src_sel = '0;
      en      = 9'h010;
      nib     = '0;
      isel    = 1'b0;
      xs      = 1'b0;
      ys      = 1'b0;
      nop_d8  = 1'b0;
      nop_df  = 1'b0;
    end
  end

  assign bus.pm_addr    = pc;
  assign bus.ir         = ir_q;
  assign bus.ir_nibble  = nib;
  assign bus.source_sel = src_sel;
  assign bus.reg_en     = en;
  assign bus.i_sel      = isel;
  assign bus.x_sel      = xs;
  assign bus.y_sel      = ys;
  assign bus.NOPD8      = nop_d8;
  assign bus.NOPDF      = nop_df;

endmodule

// File: tb/tb_program_sequencer_decoder.sv
// Self-checking bench for program_sequencer_decoder with a behavioural model.
module tb_program_sequencer_decoder;

  logic clk = 1'b0;
  logic sync_reset = 1'b1;
  logic [7:0] rom [256];

  program_sequencer_decoder_if bus ();

  program_sequencer_decoder #(
    .RESET_VECTOR (8'h00),
    .NOP_INSTR    (8'hC8)
  ) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  assign bus.pm_data = rom[bus.pm_addr];

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  int   m_pc;
  int   m_ir;
  int   m_ir_pc;
  logic cur_rst;

  function automatic logic [37:0] dut_vec();
    return {bus.pm_addr, bus.ir, bus.ir_nibble, bus.source_sel, bus.reg_en,
            bus.i_sel, bus.x_sel, bus.y_sel, bus.NOPD8, bus.NOPDF};
  endfunction

  function automatic logic [37:0] model_vec();
    int op, d, s, cls, en, src, nib;
    logic isel, xs, ys, n8, nf;
    op = m_ir; en = 0; src = 10; isel = 0; xs = 0; ys = 0;
    nib = op % 16; d = -1; s = -1;
    n8 = (op == 216); nf = (op == 223);
    cls = op / 32;
    if (op < 128) begin
      d = (op / 16) % 8; src = 8;
    end else if (op < 192) begin
      d = (op / 8) % 8; s = op % 8; src = (d == s) ? 9 : s;
    end else if (cls == 6) begin
      en = 16; xs = (op / 16) % 2; ys = (op / 8) % 2;
    end
    if (d >= 0) begin
      en = (d == 4) ? 256 : (1 << d);
      if ((d == 7 || s == 7) && d != 6) begin
        en = en + 64; isel = 1;
      end
    end
    if (cur_rst) begin
      en = 16; src = 0; nib = 0; isel = 0; xs = 0; ys = 0; n8 = 0; nf = 0;
    end
    return {8'(m_pc), 8'(m_ir), 4'(nib), 4'(src), 9'(en), isel, xs, ys, n8, nf};
  endfunction

  // Apply inputs at the falling edge, advance model, wait one full clock.
  task automatic tick(input logic rst, input logic req0);
    int word, jump, nxt;
    sync_reset  = rst;
    bus.r_eq_0  = req0;
    cur_rst     = rst;
    word = rom[m_pc];
    if (rst) begin
      m_pc = 0; m_ir = 200; m_ir_pc = 0;
    end else begin
      jump = (m_ir / 16 == 14) || (m_ir / 16 == 15 && req0 == 1'b0);
      nxt  = jump ? ((m_ir_pc / 16) * 16 + m_ir % 16) : (m_pc + 1) % 256;
      m_ir_pc = m_pc;
`ifdef JUMP_FLUSH_EN
      m_ir = jump ? 200 : word;
`else
      m_ir = word;
`endif
      m_pc = nxt;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC8;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL reset_vec got %h exp %h", dut_vec(), model_vec());
    else n_pass++;
    n_total++;
    if ({bus.pm_addr, bus.ir, bus.reg_en} !== {8'h00, 8'hC8, 9'h010})
      $display("FAIL reset_state got %h/%h/%h exp 00/c8/010", bus.pm_addr, bus.ir, bus.reg_en);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (bus.pm_addr !== 8'h01) $display("FAIL reset_rel1 got %h exp 01", bus.pm_addr);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (bus.pm_addr !== 8'h02) $display("FAIL reset_rel2 got %h exp 02", bus.pm_addr);
    else n_pass++;
  endtask

  task automatic test_decode();
    logic [7:0] t_ir [7]  = '{8'h35, 8'h48, 8'hB8, 8'hA4, 8'hB7, 8'hD8, 8'hDF};
    logic [8:0] t_en [7]  = '{9'h008, 9'h100, 9'h0C0, 9'h100, 9'h040, 9'h010, 9'h010};
    logic [3:0] t_src [7] = '{4'd8, 4'd8, 4'd0, 4'd9, 4'd7, 4'd10, 4'd10};
    logic [4:0] t_fl [7]  = '{5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b01110, 5'b01101};
    fill_nop();
    for (int i = 0; i < 7; i++) rom[i] = t_ir[i];
    tick(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1);
      n_total++;
      if ({bus.ir, bus.reg_en, bus.source_sel, bus.ir_nibble,
           bus.i_sel, bus.x_sel, bus.y_sel, bus.NOPD8, bus.NOPDF}
          !== {t_ir[i], t_en[i], t_src[i], t_ir[i][3:0], t_fl[i]})
        $display("FAIL decode_%h got en=%h src=%0d nib=%h fl=%b exp en=%h src=%0d fl=%b",
                 t_ir[i], bus.reg_en, bus.source_sel, bus.ir_nibble,
                 {bus.i_sel, bus.x_sel, bus.y_sel, bus.NOPD8, bus.NOPDF},
                 t_en[i], t_src[i], t_fl[i]);
      else n_pass++;
      n_total++;
      if (dut_vec() !== model_vec()) $display("FAIL decode_model got %h exp %h", dut_vec(), model_vec());
      else n_pass++;
    end
  endtask

  task automatic test_jnz(input logic req0, input logic rst_at_jump);
    logic [7:0] exp_pc, exp_ir;
    fill_nop();
    rom[8'h25] = 8'hF3;
    rom[8'h26] = 8'h35;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 38; i++) tick(1'b0, 1'b1);
    n_total++;
    if ({bus.ir, bus.pm_addr} !== {8'hF3, 8'h26})
      $display("FAIL jnz_setup got ir=%h pc=%h exp ir=f3 pc=26", bus.ir, bus.pm_addr);
    else n_pass++;
    tick(rst_at_jump, req0);
    if (rst_at_jump) begin
      exp_pc = 8'h00; exp_ir = 8'hC8;
    end else if (req0) begin
      exp_pc = 8'h27; exp_ir = 8'h35;
    end else begin
      exp_pc = 8'h23;
`ifdef JUMP_FLUSH_EN
      exp_ir = 8'hC8;
`else
      exp_ir = 8'h35;
`endif
    end
    n_total++;
    if ({bus.pm_addr, bus.ir} !== {exp_pc, exp_ir})
      $display("FAIL jnz_r%0d_rst%0d got pc=%h ir=%h exp pc=%h ir=%h",
               req0, rst_at_jump, bus.pm_addr, bus.ir, exp_pc, exp_ir);
    else n_pass++;
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL jnz_model got %h exp %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_wrap(input logic with_jump);
    fill_nop();
    if (with_jump) rom[8'hFE] = 8'hE0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 255; i++) tick(1'b0, 1'b0);
    n_total++;
    if (bus.pm_addr !== 8'hFF) $display("FAIL wrap_pre got %h exp ff", bus.pm_addr);
    else n_pass++;
    tick(1'b0, 1'b0);
    n_total++;
    if (bus.pm_addr !== (with_jump ? 8'hF0 : 8'h00))
      $display("FAIL wrap_j%0d got %h exp %h", with_jump, bus.pm_addr, with_jump ? 8'hF0 : 8'h00);
    else n_pass++;
    n_total++;
    if (dut_vec() !== model_vec()) $display("FAIL wrap_model got %h exp %h", dut_vec(), model_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 31) == 0), 1'($urandom));
      n_total++;
      if (dut_vec() !== model_vec()) begin
        if (bad < 10) $display("FAIL random_c%0d got %h exp %h", i, dut_vec(), model_vec());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    bus.r_eq_0 = 1'b0;
    cur_rst = 1'b1;
    m_pc = 0; m_ir = 200; m_ir_pc = 0;
    @(negedge clk);
    test_reset();
    test_decode();
    test_jnz(1'b0, 1'b0);
    test_jnz(1'b1, 1'b0);
    test_jnz(1'b0, 1'b1);
    test_wrap(1'b1);
    test_wrap(1'b0);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
